// File: rtl/weight_loader.sv
// ============================================================================
// Module   : weight_loader
// Purpose  : Streams weight bytes into the 16-entry weight memory at addresses
//            0..count-1, keeps a mod-2^DATA_W checksum and pulses done/error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(DEPTH);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   index, index_nx;
  logic [ADDR_W-1:0]   last_idx, last_idx_nx;
  // tail: the final write is on the memory port this cycle; LOAD is draining
  logic                tail, tail_nx;

  logic [DATA_W-1:0]   mem_data_nx;
  logic [ADDR_W-1:0]   mem_addr_nx;
  logic                mem_wr_nx;
  logic                done_nx;
  logic                error_nx;
  logic [DATA_W-1:0]   checksum_nx;
  logic                busy_nx;
  logic                s_ready_nx;

  logic                count_ok;
  logic                xfer;

  assign count_ok = (count != '0) && (count <= MAX_COUNT);
  assign xfer     = s_valid & s_ready;

  always_comb begin
    state_nx    = state;
    index_nx    = index;
    last_idx_nx = last_idx;
    tail_nx     = tail;
    mem_data_nx = mem_data;
    mem_addr_nx = mem_addr;
    mem_wr_nx   = 1'b0;
    done_nx     = 1'b0;
    error_nx    = 1'b0;
    checksum_nx = checksum;

    case (state)
      IDLE: begin
        if (start) begin
          if (count_ok) begin
            state_nx    = LOAD;
            // count == DEPTH wraps cleanly to the all-ones index
            last_idx_nx = count[ADDR_W-1:0] - ADDR_W'(1);
            index_nx    = '0;
            tail_nx     = 1'b0;
            checksum_nx = '0;
          end else begin
            error_nx    = 1'b1;
          end
        end
      end

      LOAD: begin
        if (xfer) begin
          mem_wr_nx   = 1'b1;
          mem_data_nx = s_data;
          mem_addr_nx = index;
          checksum_nx = checksum + s_data;
          if (index == last_idx) begin
            tail_nx  = 1'b1;
          end else begin
            index_nx = index + ADDR_W'(1);
          end
        end

        if (abort) begin
          state_nx = IDLE;
          tail_nx  = 1'b0;
        end else if (tail) begin
          // the last write was captured by the memory at this edge
          state_nx = FINISH;
          done_nx  = 1'b1;
          tail_nx  = 1'b0;
        end
      end

      FINISH: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
        tail_nx  = 1'b0;
      end
    endcase

    busy_nx    = (state_nx != IDLE);
    s_ready_nx = (state_nx == LOAD) && !tail_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      index    <= '0;
      last_idx <= '0;
      tail     <= 1'b0;
      mem_data <= '0;
      mem_addr <= '0;
      mem_wr   <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      checksum <= '0;
      busy     <= 1'b0;
      s_ready  <= 1'b0;
    end else begin
      state    <= state_nx;
      index    <= index_nx;
      last_idx <= last_idx_nx;
      tail     <= tail_nx;
      mem_data <= mem_data_nx;
      mem_addr <= mem_addr_nx;
      mem_wr   <= mem_wr_nx;
      done     <= done_nx;
      error    <= error_nx;
      checksum <= checksum_nx;
      busy     <= busy_nx;
      s_ready  <= s_ready_nx;
    end
  end

endmodule

`default_nettype wire
